// File: rtl/cc_onehot_monitor_if.sv
// Valid/ready stream carrying a checked vector and its one-hot flag into and out of the monitor.
interface cc_onehot_monitor_if #(
    parameter int unsigned Width = 4
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [Width-1:0] in_data_i;
    logic             in_onehot_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [Width-1:0] out_data_o;
    logic             out_legal_o;

    // Monitor side: consumes the input stream, produces the registered output stream
    modport slave (
        input  in_valid_i, in_data_i, in_onehot_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_legal_o
    );

    // Environment side: drives the input stream, consumes the output stream
    modport master (
        output in_valid_i, in_data_i, in_onehot_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_legal_o
    );
endinterface

// File: rtl/cc_onehot_monitor.sv
// Registered one-hot checking stage: one-deep valid/ready pipeline register plus
// sticky error flag, saturating violation counter and first-offender capture.
module cc_onehot_monitor #(
    parameter int unsigned Width     = 4,
    parameter int unsigned CntWidth  = 8,
    parameter bit          AllowZero = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    cc_onehot_monitor_if.slave  bus,
    output logic                err_o,
    output logic [CntWidth-1:0] err_cnt_o,
    output logic [Width-1:0]    first_err_data_o
);
    localparam logic [CntWidth-1:0] CntMax = '1;

    typedef enum logic {
        ST_CLEAN = 1'b0,
        ST_ERROR = 1'b1
    } state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [CntWidth-1:0] r_cnt;
    logic [CntWidth-1:0] w_cnt_nxt;
    logic [Width-1:0]    r_cap;
    logic [Width-1:0]    w_cap_nxt;

    logic                r_out_valid;
    logic [Width-1:0]    r_out_data;
    logic                r_out_legal;

    logic                w_ready;
    logic                w_accept;
    logic                w_legal;
    logic                w_viol;

    // Handshake and per-beat legality; ready never depends on in_valid_i
    assign w_ready  = ~r_out_valid | bus.out_ready_i;
    assign w_accept = bus.in_valid_i & w_ready;
    assign w_legal  = bus.in_onehot_i | (AllowZero & ~(|bus.in_data_i));
    assign w_viol   = w_accept & ~w_legal;

    // Pipeline register: load on accept, drain when downstream takes the beat, else hold
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_legal <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.in_data_i;
            r_out_legal <= w_legal;
        end else if (bus.out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    // Error-tracking state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_CLEAN;
            r_cnt   <= '0;
            r_cap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cap   <= w_cap_nxt;
        end
    end

    // Next state: clear first, then a same-cycle violation is applied on top of it
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cap_nxt   = r_cap;
        if (clear_i) begin
            w_state_nxt = ST_CLEAN;
            w_cnt_nxt   = '0;
            w_cap_nxt   = '0;
        end
        if (w_viol) begin
            if (w_state_nxt == ST_CLEAN) begin
                w_state_nxt = ST_ERROR;
                w_cap_nxt   = bus.in_data_i;
            end
            if (w_cnt_nxt != CntMax) begin
                w_cnt_nxt = w_cnt_nxt + CntWidth'(1);
            end
        end
    end

    assign bus.in_ready_o  = w_ready;
    assign bus.out_valid_o = r_out_valid;
    assign bus.out_data_o  = r_out_data;
    assign bus.out_legal_o = r_out_legal;

    assign err_o            = (r_state == ST_ERROR);
    assign err_cnt_o        = r_cnt;
    assign first_err_data_o = r_cap;
endmodule

// File: doc/cc_onehot_monitor.md
Name: cc_onehot_monitor

Overview:
- Registered checking stage placed directly downstream of the combinational one-hot checker. It consumes that checker's `is_onehot` result for select/grant vectors flowing through a valid/ready stream.
- Adds one pipeline register with a full valid/ready handshake and forwards each vector together with its per-beat one-hot flag.
- Keeps sticky error state, a saturating violation counter and a capture of the first offending vector, all for status/CSR readout.

Parameters:
- Width, 4, width of the checked vector; must be >= 1.
- CntWidth, 8, width of the violation counter; must be >= 1.
- AllowZero, 0, if 1 an all-zero vector is legal and not a violation.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- clear_i  in  1  clears sticky error, counter and capture register.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when high together with in_valid_i.
- in_data_i  in  Width  vector to check.
- in_onehot_i  in  1  one-hot result for in_data_i from the combinational checker.
- out_valid_o  out  1  registered beat valid.
- out_ready_i  in  1  downstream ready.
- out_data_o  out  Width  registered vector.
- out_legal_o  out  1  registered legality of out_data_o.
- err_o  out  1  sticky violation flag.
- err_cnt_o  out  CntWidth  saturating count of violating beats.
- first_err_data_o  out  Width  first violating vector since reset or clear.

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is synchronous and active-high.
- Reset values: out_valid_o=0, out_data_o=0, out_legal_o=0, err_o=0, err_cnt_o=0, first_err_data_o=0, FSM=CLEAN.
- Ready: in_ready_o = ~out_valid_o | out_ready_i. This is combinational, with no path from in_valid_i.
- Accept: a beat is accepted when in_valid_i & in_ready_o.
- Legality: legal = in_onehot_i | (AllowZero & ~|in_data_i).
- Pipeline register:
  - On accept, load out_data_o<=in_data_i, out_legal_o<=legal, out_valid_o<=1. Latency is exactly 1 cycle.
  - If there is no accept and out_ready_i=1, then out_valid_o<=0.
  - If there is no accept and out_ready_i=0, the output holds stable (data and legal unchanged while valid and not ready).
  - Simultaneous output drain and input accept gives back-to-back throughput of 1 beat/cycle.
- Violation: an accepted beat with legal=0. Checking happens only at accept. Non-accepted cycles are never counted, even if in_data_i is illegal.
- FSM:
  - CLEAN: on violation, go to ERROR; capture first_err_data_o<=in_data_i.
  - ERROR: first_err_data_o holds; further violations only increment the counter. clear_i=1 returns to CLEAN.
  - err_o=1 exactly in state ERROR, and it is registered.
- Counter: increments by 1 per violation and saturates at 2**CntWidth-1, with no wrap.
- clear_i:
  - Zeros the counter and capture register and moves to CLEAN.
  - It does not affect the pipeline register or handshake.
  - If clear_i and a violation occur in the same cycle, the violation is applied after the clear. Result next cycle: FSM=ERROR, err_cnt_o=1, first_err_data_o=that vector.
- Reset mid-operation: rst_i overrides everything, including a pending beat and clear_i. A beat held on the output at reset is dropped.
- Width==1: one-hot equals the bit value. With AllowZero=1 every beat is legal.

Test Plan:
1. Reset then idle, Width=4: all outputs 0 and in_ready_o=1.
2. Stream 0001,0010,0100,1000 with out_ready_i=1 constantly:
   - out_valid_o is high 1 cycle after each accept, with data in order and out_legal_o=1.
   - err_o=0, err_cnt_o=0.
3. Backpressure: send 0010, hold out_ready_i=0 for 3 cycles while presenting 0100:
   - in_ready_o=0 and out_data_o stays 0010.
   - Raising out_ready_i transfers 0010 and then 0100. No beat is lost or duplicated.
4. Violations, AllowZero=0: accept 0110, then 0000, then 1000:
   - err_o=1 from the cycle after 0110.
   - first_err_data_o=0110.
   - err_cnt_o=2 after the third beat; out_legal_o sequence is 0,0,1.
5. Saturation, CntWidth=2: 5 illegal beats (e.g. 1111) give err_cnt_o=3, held, with no wrap.
6. Clear collision: in ERROR with count=2, assert clear_i in the same cycle 1100 is accepted:
   - Next cycle err_o=1, err_cnt_o=1, first_err_data_o=1100.
   - clear_i with no violation gives err_o=0, err_cnt_o=0, first_err_data_o=0.
